// File: rtl/snake_screen_ctrl_if.sv
// Pixel-path bundle between the TFT timing generator, title ROM, game core and LCD driver.
// The screen controller takes the slave side; the surrounding fabric drives the master side.
interface snake_screen_ctrl_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        vsync;
  logic [23:0] play_rgb;
  logic        rom_q;
  logic [15:0] rom_addr;
  logic [23:0] rgb_data;

  modport master (
    output pix_x, pix_y, vsync, play_rgb, rom_q,
    input  rom_addr, rgb_data
  );

  modport slave (
    input  pix_x, pix_y, vsync, play_rgb, rom_q,
    output rom_addr, rgb_data
  );
endinterface

// File: rtl/snake_screen_ctrl.sv
// SNAKE screen-mode sequencer (TITLE -> PLAY -> OVER -> TITLE): title-ROM addressing,
// frame-gated key detection and the 3-stage pixel mux feeding the LCD driver.
module snake_screen_ctrl #(
  parameter int unsigned IMG_X0       = 221,
  parameter int unsigned IMG_Y0       = 141,
  parameter int unsigned IMG_W        = 200,
  parameter int unsigned IMG_H        = 200,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned OVER_HOLD    = 120
) (
  input  logic                 tft_clk_9m,
  input  logic                 sys_rst,
  snake_screen_ctrl_if.slave   pix,
  input  logic                 key_start,
  input  logic                 game_over,
  output logic                 game_run,
  output logic [1:0]           scr_state
);

  localparam int unsigned CNT_MAX = (BLINK_FRAMES > OVER_HOLD) ? BLINK_FRAMES : OVER_HOLD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [15:0]   X0         = 16'(IMG_X0);
  localparam logic [15:0]   Y0         = 16'(IMG_Y0);
  localparam logic [15:0]   X_END      = 16'(IMG_X0 + IMG_W);
  localparam logic [15:0]   Y_END      = 16'(IMG_Y0 + IMG_H);
  localparam logic [15:0]   W16        = 16'(IMG_W);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_MAX   = CW'(OVER_HOLD);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic [1:0]    key_hist_q, key_hist_d;
  logic          run_q, run_d;
  logic          vs_d1_q, vs_d1_d;
  logic          vs_d2_q, vs_d2_d;
  logic          win_d1_q, win_d1_d;
  logic          win_d2_q, win_d2_d;
  logic [23:0]   play_d1_q, play_d1_d;
  logic [23:0]   play_d2_q, play_d2_d;
  logic [15:0]   rom_addr_q, rom_addr_d;
  logic [23:0]   rgb_q, rgb_d;

  logic        fs, press, in_win;
  logic [15:0] x16, y16, dx, dy;

  assign fs    = pix.vsync & ~vs_d1_q;
  assign press = fs & key_start & key_hist_q[0] & ~key_hist_q[1];

  assign x16    = {6'd0, pix.pix_x};
  assign y16    = {6'd0, pix.pix_y};
  assign dx     = x16 - X0;
  assign dy     = y16 - Y0;
  assign in_win = (x16 >= X0) && (x16 < X_END) && (y16 >= Y0) && (y16 < Y_END);

  always_comb begin
    vs_d1_d    = pix.vsync;
    vs_d2_d    = vs_d1_q;
    win_d1_d   = in_win;
    win_d2_d   = win_d1_q;
    play_d1_d  = pix.play_rgb;
    play_d2_d  = play_d1_q;
    rom_addr_d = in_win ? (dy * W16 + dx) : '0;

    // E3 mux uses the mode current at E3, not the mode when the pixel entered.
    rgb_d = '0;
    if (vs_d2_q) begin
      unique case (state_q)
        TITLE:   rgb_d = (win_d2_q & pix.rom_q & blink_q) ? 24'hFFFFFF : 24'h000000;
        PLAY:    rgb_d = play_d2_q;
        OVER:    rgb_d = (win_d2_q & pix.rom_q) ? 24'hFF0000 : 24'h000000;
        default: rgb_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blink_d    = blink_q;
    pend_d     = pend_q;
    run_d      = (state_q == PLAY);
    key_hist_d = fs ? {key_hist_q[0], key_start} : key_hist_q;

    unique case (state_q)
      TITLE: begin
        if (press) begin
          state_d = PLAY;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (fs) begin
          if (cnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PLAY: begin
        // A game_over landing on the fs cycle itself still ends the game at that edge.
        if (fs && (pend_q || game_over)) begin
          state_d = OVER;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (game_over) begin
          pend_d = 1'b1;
        end
      end
      OVER: begin
        if (press && (cnt_q == HOLD_MAX)) begin
          state_d = TITLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
          blink_d = 1'b1;
        end else if (fs && (cnt_q != HOLD_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = TITLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
        blink_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge tft_clk_9m) begin
    if (sys_rst) begin
      state_q    <= TITLE;
      cnt_q      <= '0;
      blink_q    <= 1'b1;
      pend_q     <= 1'b0;
      key_hist_q <= '0;
      run_q      <= 1'b0;
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      win_d1_q   <= 1'b0;
      win_d2_q   <= 1'b0;
      play_d1_q  <= '0;
      play_d2_q  <= '0;
      rom_addr_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      pend_q     <= pend_d;
      key_hist_q <= key_hist_d;
      run_q      <= run_d;
      vs_d1_q    <= vs_d1_d;
      vs_d2_q    <= vs_d2_d;
      win_d1_q   <= win_d1_d;
      win_d2_q   <= win_d2_d;
      play_d1_q  <= play_d1_d;
      play_d2_q  <= play_d2_d;
      rom_addr_q <= rom_addr_d;
      rgb_q      <= rgb_d;
    end
  end

  assign pix.rom_addr = rom_addr_q;
  assign pix.rgb_data = rgb_q;
  assign game_run     = run_q;
  assign scr_state    = state_q;

endmodule

// File: tb/tb_snake_screen_ctrl.sv
// Self-checking bench for snake_screen_ctrl: randomized pixels/frames against a frame-level
// behavioural model, plus directed checks of the mode-sequencing corner cases.
module tb_snake_screen_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start;
  logic       game_over;
  logic       game_run;
  logic [1:0] scr_state;

  int n_chk  = 0;
  int n_pass = 0;

  snake_screen_ctrl_if bus();

  snake_screen_ctrl #(
    .IMG_X0(221), .IMG_Y0(141), .IMG_W(200), .IMG_H(200),
    .BLINK_FRAMES(30), .OVER_HOLD(120)
  ) dut (
    .tft_clk_9m(clk),
    .sys_rst(rst),
    .pix(bus),
    .key_start(key_start),
    .game_over(game_over),
    .game_run(game_run),
    .scr_state(scr_state)
  );

  always #5 clk = ~clk;

  function automatic logic rom_fn(input int a);
    return (a % 5) != 1;
  endfunction

  // Registered title ROM with one cycle of latency.
  always @(posedge clk) bus.rom_q <= rom_fn(int'(bus.rom_addr));

  typedef struct {
    bit          win;
    int          addr;
    bit          vs;
    logic [23:0] rgb;
  } px_t;

  px_t         hist[$];
  int          m_state, m_cnt;
  bit          m_blink, m_pend, m_kh0, m_kh1, m_vsd;
  logic [23:0] exp_rgb;
  int          exp_addr;
  bit          exp_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step();
    px_t cur, old;
    bit  fs, press;
    int  x, y;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_blink = 1; m_pend = 0;
      m_kh0 = 0; m_kh1 = 0; m_vsd = 0;
      exp_rgb = '0; exp_addr = 0; exp_run = 0;
      hist.delete();
      hist.push_front('{0, 0, 0, 24'h0});
      hist.push_front('{0, 0, 0, 24'h0});
    end else begin
      x = int'(bus.pix_x);
      y = int'(bus.pix_y);
      cur.win  = (x >= 221) && (x < 421) && (y >= 141) && (y < 341);
      cur.addr = cur.win ? (y - 141) * 200 + (x - 221) : 0;
      cur.vs   = bus.vsync;
      cur.rgb  = bus.play_rgb;
      hist.push_front(cur);
      old = hist[2];
      void'(hist.pop_back());
      exp_addr = cur.addr;
      if (!old.vs) exp_rgb = 24'h0;
      else if (m_state == 0) exp_rgb = (old.win && rom_fn(old.addr) && m_blink) ? 24'hFFFFFF : 24'h0;
      else if (m_state == 1) exp_rgb = old.rgb;
      else exp_rgb = (old.win && rom_fn(old.addr)) ? 24'hFF0000 : 24'h0;
      exp_run = (m_state == 1);

      fs    = bus.vsync && !m_vsd;
      press = fs && key_start && m_kh0 && !m_kh1;
      if (fs) begin
        m_kh1 = m_kh0;
        m_kh0 = key_start;
      end
      if (m_state == 0) begin
        if (press) begin
          m_state = 1; m_cnt = 0; m_pend = 0;
        end else if (fs) begin
          m_cnt++;
          if (m_cnt == 30) begin
            m_cnt = 0; m_blink = !m_blink;
          end
        end
      end else if (m_state == 1) begin
        if (fs && (m_pend || game_over)) begin
          m_state = 2; m_cnt = 0; m_pend = 0;
        end else if (game_over) m_pend = 1;
      end else begin
        if (press && m_cnt == 120) begin
          m_state = 0; m_cnt = 0; m_pend = 0; m_blink = 1;
        end else if (fs && m_cnt < 120) m_cnt++;
      end
      m_vsd = bus.vsync;
    end
    @(posedge clk);
    #1;
    chk("scr_state", 32'(scr_state), 32'(m_state));
    chk("game_run", 32'(game_run), 32'(exp_run));
    chk("rgb_data", 32'(bus.rgb_data), 32'(exp_rgb));
    chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
  endtask

  task automatic set_px(input int x, input int y);
    bus.pix_x    = 10'(x);
    bus.pix_y    = 10'(y);
    bus.play_rgb = 24'($urandom);
  endtask

  task automatic rand_px();
    if ($urandom_range(1, 0) == 1) set_px($urandom_range(426, 215), $urandom_range(346, 135));
    else set_px($urandom_range(1023, 0), $urandom_range(1023, 0));
  endtask

  task automatic frame(input int act, input bit go_mid, input bit go_fs);
    bus.vsync = 1'b0;
    game_over = 1'b0;
    repeat (2) begin
      rand_px();
      step();
    end
    bus.vsync = 1'b1;
    for (int i = 0; i < act; i++) begin
      rand_px();
      game_over = (go_fs && i == 0) || (go_mid && i == act / 2);
      step();
    end
    game_over = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(8, 1'b0, 1'b0);
  endtask

  task automatic do_press();
    key_start = 1'b0; frame(8, 1'b0, 1'b0);
    key_start = 1'b1; frame(8, 1'b0, 1'b0);
    frame(8, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_start = 1'b0; game_over = 1'b0;
    bus.vsync = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.play_rgb = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_state", 32'(scr_state), 32'd0);
    chk("reset_rgb", 32'(bus.rgb_data), 32'd0);

    // Window corners and edges in TITLE with a visible blink phase.
    bus.vsync = 1'b1;
    set_px(221, 141); step(); chk("addr_first", 32'(bus.rom_addr), 32'd0);
    set_px(420, 340); step(); chk("addr_last", 32'(bus.rom_addr), 32'd39999);
    set_px(220, 141); step(); chk("addr_left_out", 32'(bus.rom_addr), 32'd0);
    chk("rgb_first", 32'(bus.rgb_data), 32'hFFFFFF);
    set_px(421, 200); step(); chk("rgb_last", 32'(bus.rgb_data), 32'hFFFFFF);
    set_px(300, 341); step(); chk("rgb_left_out", 32'(bus.rgb_data), 32'h0);
    set_px(221, 140); step();
    set_px(221, 340); step();

    frames(64);
    do_press();
    chk("enter_play", 32'(scr_state), 32'd1);
    frames(2);
    key_start = 1'b0;
    frames(2);

    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("rst_play_state", 32'(scr_state), 32'd0);
    chk("rst_play_run", 32'(game_run), 32'd0);
    chk("rst_play_rgb", 32'(bus.rgb_data), 32'd0);
    chk("rst_play_addr", 32'(bus.rom_addr), 32'd0);

    frames(1);
    do_press();
    key_start = 1'b0;
    frame(8, 1'b0, 1'b1);
    chk("over_on_fs", 32'(scr_state), 32'd2);

    frames(47);
    key_start = 1'b1;
    frames(3);
    chk("early_press_ignored", 32'(scr_state), 32'd2);
    key_start = 1'b0;
    frames(75);
    key_start = 1'b1;
    frames(2);
    chk("over_to_title", 32'(scr_state), 32'd0);
    key_start = 1'b0;

    frame(8, 1'b1, 1'b0);
    frame(8, 1'b0, 1'b1);
    chk("title_ignores_over", 32'(scr_state), 32'd0);

    do_press();
    key_start = 1'b0;
    frames(2);
    frame(8, 1'b1, 1'b0);
    chk("pend_waits_fs", 32'(scr_state), 32'd1);
    frame(8, 1'b0, 1'b0);
    chk("pend_to_over", 32'(scr_state), 32'd2);
    frames(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
